gcd_stream_arbiter: RTL and testbench

//  Shares one GCD core among NUM_REQ requesters. Round-robin grant; one job per grant.
//  Per job: streams SAMPLES_PER_JOB nibbles from the winner into core in_valid/in_data.

---
 rtl/gcd_stream_arbiter_if.sv | 35 +++
 rtl/gcd_stream_arbiter.sv | 174 +++++++++++++++++
 tb/tb_gcd_stream_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_stream_arbiter_if.sv
// Client/core handshake bundle for gcd_stream_arbiter.
// master = clients + core side, slave = arbiter.
interface gcd_stream_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic                 data_ack;
  logic                 core_in_valid;
  logic [3:0]           core_in_data;
  logic                 core_out_valid;
  logic [4:0]           core_out_data;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [4:0]           rsp_data;
  logic                 rsp_last;

  modport master (
    output req, req_data,
    output core_out_valid, core_out_data,
    input  grant, data_ack,
    input  core_in_valid, core_in_data,
    input  rsp_valid, rsp_id, rsp_data, rsp_last
  );

  modport slave (
    input  req, req_data,
    input  core_out_valid, core_out_data,
    output grant, data_ack,
    output core_in_valid, core_in_data,
    output rsp_valid, rsp_id, rsp_data, rsp_last
  );
endinterface

// File: rtl/gcd_stream_arbiter.sv
// Round-robin arbiter sharing one GCD core among NUM_REQ clients.
// Define GCD_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module gcd_stream_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int SAMPLES_PER_JOB = 7,
  parameter int RESULTS_PER_JOB = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int TIMEOUT_CYCLES  = 32
) (
  input  logic clk,
  input  logic rst_n,
  gcd_stream_arbiter_if.slave bus,
  output logic busy,
  output logic err_sticky,
  output logic timeout
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int M1 = (SAMPLES_PER_JOB > RESULTS_PER_JOB) ?
                      SAMPLES_PER_JOB : RESULTS_PER_JOB;
  localparam int M2 = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
  localparam int MX = (M2 > TIMEOUT_CYCLES) ? M2 : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MX) + 1;

  typedef enum logic [2:0] {
    IDLE, GRANT, FEED, WAIT, GAP
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] pick;
  logic [CW-1:0]  cnt;
  logic [3:0]     sel_data;
  logic           fin;

  function automatic logic [IDW-1:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [IDW-1:0]     p
  );
    logic [IDW-1:0] w;
    logic           hit;
    int             j;
    w   = '0;
    hit = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(p) + i) % NUM_REQ;
      if (!hit && r[IDW'(j)]) begin
        hit = 1'b1;
        w   = IDW'(j);
      end
    end
    return w;
  endfunction

  assign pick = rr_pick(bus.req, ptr);

  always_comb begin
    sel_data = 4'h0;
    for (int i = 0; i < NUM_REQ; i++)
      if (winner == IDW'(i))
        sel_data = bus.req_data[4*i +: 4];
  end

  assign fin = bus.core_out_valid &&
               (cnt == CW'(RESULTS_PER_JOB - 1));

  assign busy         = (state != IDLE);
  assign bus.data_ack = (state == FEED);

`ifdef GCD_ARB_TIMEOUT_EN
  logic [CW-1:0] wdog;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      ptr               <= IDW'(NUM_REQ - 1);
      winner            <= '0;
      cnt               <= '0;
      bus.grant         <= '0;
      bus.core_in_valid <= 1'b0;
      bus.core_in_data  <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_id        <= '0;
      bus.rsp_data      <= '0;
      bus.rsp_last      <= 1'b0;
      err_sticky        <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      wdog              <= '0;
      timeout           <= 1'b0;
`endif
    end else begin
      bus.core_in_valid <= 1'b0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_last      <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      timeout           <= 1'b0;
`endif
      if (bus.core_out_valid && state != WAIT)
        err_sticky <= 1'b1;
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            winner    <= pick;
            ptr       <= pick;
            bus.grant <= NUM_REQ'(1) << pick;
            state     <= GRANT;
          end
        end
        GRANT: begin
          cnt   <= '0;
          state <= FEED;
        end
        FEED: begin
          bus.core_in_valid <= 1'b1;
          bus.core_in_data  <= sel_data;
          if (cnt == CW'(SAMPLES_PER_JOB - 1)) begin
            cnt   <= '0;
            state <= WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
            wdog  <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
`ifdef GCD_ARB_TIMEOUT_EN
          wdog <= wdog + 1'b1;
`endif
          if (fin) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= winner;
            bus.rsp_data  <= bus.core_out_data;
            bus.rsp_last  <= 1'b1;
            bus.grant     <= '0;
            cnt           <= '0;
            state         <= GAP;
          end
`ifdef GCD_ARB_TIMEOUT_EN
          // watchdog expiry closes the job with a zero beat
          else if (wdog == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout       <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= winner;
            bus.rsp_data  <= '0;
            bus.rsp_last  <= 1'b1;
            bus.grant     <= '0;
            cnt           <= '0;
            state         <= GAP;
          end
`endif
          else if (bus.core_out_valid) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= winner;
            bus.rsp_data  <= bus.core_out_data;
            cnt           <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_stream_arbiter.sv
// Randomized self-checking bench for gcd_stream_arbiter.
// Core stub + cycle-level reference model driven from one negedge task.
module tb_gcd_stream_arbiter;
  localparam int NR   = 4;
  localparam int SPJ  = 7;
  localparam int RPJ  = 4;
  localparam int GAPC = 2;
  localparam int TOC  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err_sticky, timeout;

  gcd_stream_arbiter_if #(.NUM_REQ(NR)) bus ();

  gcd_stream_arbiter #(
    .NUM_REQ(NR), .SAMPLES_PER_JOB(SPJ), .RESULTS_PER_JOB(RPJ),
    .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .err_sticky(err_sticky), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  int ptr_m, job_w, cool, feed_left, wcnt, n_rx, res_i, res_n, res_gap;
  bit job_on, prev_ack, err_m, in_wait, stray, stall, t1_mode;
  bit due_v, due_l;
  int due_id;
  logic [4:0] due_d;
  logic [3:0] exp_fed[$];
  int d_rx[SPJ];
  logic [4:0] res[RPJ];
  int glog[$];
  logic [4:0] rlog[$];
  int jobs_done, job_acks, job_fed, job_beats;
  int last_id, last_fed, last_beats, n_to;
  logic [3:0] t1_seq[SPJ] = '{4'd2, 4'd4, 4'd6, 4'd3, 4'd5, 4'd8, 4'd1};

  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int rr_next(input logic [NR-1:0] r, input int p);
    for (int i = 1; i <= NR; i++)
      if (r[(p + i) % NR]) return (p + i) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    ptr_m = NR - 1; job_on = 0; cool = 0; feed_left = 0;
    prev_ack = 0; err_m = 0; in_wait = 0; wcnt = 0;
    stray = 0; due_v = 0; n_rx = 0; res_i = 0; res_n = 0;
    exp_fed.delete();
  endtask

  task automatic cyc();
    bit tv, tl, to_e, ack_e;
    int tid, w, s1, s2;
    logic [4:0] td;
    @(negedge clk);
    for (int i = 0; i < NR; i++)
      bus.req_data[4*i +: 4] = 4'($urandom_range(0, 15));
    if (t1_mode && job_on && job_acks < SPJ)
      bus.req_data[3:0] = t1_seq[job_acks];
    // response beat expected this cycle
    tv = due_v; tl = due_l; tid = due_id; td = due_d; to_e = 0;
    due_v = 0;
    if (in_wait) begin
      wcnt++;
`ifdef GCD_ARB_TIMEOUT_EN
      if (wcnt == TOC) begin
        to_e = 1; tv = 1; tl = 1; tid = job_w; td = '0;
        in_wait = 0;
      end
`endif
    end
    chk("timeout", timeout, to_e);
    if (to_e && timeout) n_to++;
    chk("rsp_valid", bus.rsp_valid, tv);
    if (tv) begin
      chk("rsp_id", bus.rsp_id, tid);
      chk("rsp_data", bus.rsp_data, td);
      chk("rsp_last", bus.rsp_last, tl);
      job_beats++;
      rlog.push_back(bus.rsp_data);
      if (tl) begin
        job_on = 0; cool = GAPC + 1; jobs_done++;
        last_id = tid; last_fed = job_fed; last_beats = job_beats;
      end
    end
    chk("err_sticky", err_sticky, err_m);
    // core input: one nibble per ack, one cycle later
    chk("core_in_valid", bus.core_in_valid, prev_ack);
    if (prev_ack) begin
      if (exp_fed.size() > 0)
        chk("core_in_data", bus.core_in_data, exp_fed.pop_front());
      else
        chk("core_in_q", 0, 1);
      job_fed++;
      if (n_rx < SPJ) d_rx[n_rx] = int'(bus.core_in_data);
      n_rx++;
      if (n_rx == SPJ) begin
        s1 = d_rx[0] + d_rx[1];
        s2 = d_rx[3] + d_rx[4];
        res[0] = 5'(s1); res[1] = 5'(s2);
        res[2] = 5'(s1 + s2); res[3] = 5'(gcd(s1, s2));
        res_n = stall ? 2 : RPJ; res_i = 0;
        res_gap = $urandom_range(0, 2);
        in_wait = 1; wcnt = 0;
      end
    end
    ack_e = job_on && feed_left > 0;
    chk("data_ack", bus.data_ack, ack_e);
    if (ack_e) begin
      feed_left--;
      exp_fed.push_back(bus.req_data[4*job_w +: 4]);
      job_acks++;
    end
    prev_ack = ack_e;
    // arbitration
    if (job_on) chk("grant_hold", bus.grant, 32'(1) << job_w);
    else if (cool > 0) begin
      cool--;
      chk("grant_gap", bus.grant, 0);
    end else begin
      w = rr_next(bus.req, ptr_m);
      if (w < 0) chk("grant_idle", bus.grant, 0);
      else begin
        chk("grant_rr", bus.grant, 32'(1) << w);
        ptr_m = w; job_w = w; job_on = 1; feed_left = SPJ;
        glog.push_back(w); rlog.delete();
        job_acks = 0; job_fed = 0; job_beats = 0; n_rx = 0;
      end
    end
    chk("busy", busy, job_on || cool > 0);
    // core stub
    bus.core_out_valid = 1'b0;
    bus.core_out_data  = 5'($urandom_range(0, 31));
    if (stray) begin
      bus.core_out_valid = 1'b1;
      err_m = 1; stray = 0;
    end else if (in_wait && res_i < res_n) begin
      if (res_gap > 0) res_gap--;
      else begin
        bus.core_out_valid = 1'b1;
        bus.core_out_data  = res[res_i];
        due_v = 1; due_id = job_w; due_d = res[res_i];
        due_l = (res_i == RPJ - 1);
        if (due_l) in_wait = 0;
        res_i++;
        res_gap = $urandom_range(0, 2);
      end
    end
  endtask

  task automatic wait_jobs(input int n, input int budget);
    int tgt, c;
    tgt = jobs_done + n;
    c = 0;
    while (jobs_done < tgt && c < budget) begin
      cyc();
      c++;
    end
    chk("job_budget", jobs_done >= tgt, 1);
  endtask

  task automatic start_job(input logic [NR-1:0] m);
    int c;
    bus.req = m;
    c = 0;
    while (!job_on && c < 20) begin
      cyc();
      c++;
    end
    chk("start_budget", job_on, 1);
  endtask

  initial begin
    int c, n;
    int t2_exp[5] = '{0, 1, 2, 3, 0};
    bus.req = '0; bus.req_data = '0;
    bus.core_out_valid = 1'b0; bus.core_out_data = '0;
    stall = 0; t1_mode = 0; jobs_done = 0; n_to = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_civ", bus.core_in_valid, 0);
    chk("rst_rsp", bus.rsp_valid, 0);
    chk("rst_err", err_sticky, 0);
    rst_n = 1'b1;

    // T2 contention from reset
    bus.req = '1;
    wait_jobs(5, 400);
    bus.req = '0;
    for (int i = 0; i < 5; i++)
      chk("t2_order", glog[i], t2_exp[i]);
    repeat (4) cyc();

    // T1 single job with fixed stream
    t1_mode = 1;
    start_job(4'b0001);
    wait_jobs(1, 100);
    t1_mode = 0;
    chk("t1_id", last_id, 0);
    chk("t1_r0", rlog[0], 6);
    chk("t1_r1", rlog[1], 8);
    chk("t1_r2", rlog[2], 14);
    chk("t1_r3", rlog[3], 2);
    for (int i = 0; i < SPJ; i++)
      chk("t1_fed", d_rx[i], t1_seq[i]);
    n = 0;
    while (busy && n < 10) begin
      cyc();
      n++;
    end
    chk("t1_gap", n, GAPC);

    // T3 requester drops mid-feed
    bus.req = 4'b0010;
    c = 0;
    while (!(job_on && job_acks == 3) && c < 30) begin
      cyc();
      c++;
    end
    bus.req = '0;
    wait_jobs(1, 100);
    chk("t3_fed", last_fed, SPJ);
    chk("t3_beats", last_beats, RPJ);
    chk("t3_id", last_id, 1);
    repeat (5) cyc();

    // T4 stray core beat while idle
    stray = 1;
    repeat (4) cyc();
    chk("t4_err", err_sticky, 1);

    // T5 reset mid-feed
    bus.req = 4'b0100;
    c = 0;
    while (!(job_on && job_fed == 4) && c < 30) begin
      cyc();
      c++;
    end
    bus.req = '0;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_grant", bus.grant, 0);
    chk("t5_ack", bus.data_ack, 0);
    chk("t5_civ", bus.core_in_valid, 0);
    chk("t5_cid", bus.core_in_data, 0);
    chk("t5_rsp", bus.rsp_valid, 0);
    chk("t5_err", err_sticky, 0);
    chk("t5_to", timeout, 0);
    model_reset();
    bus.core_out_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_job(4'b1111);
    bus.req = '0;
    chk("t5_first", glog[glog.size() - 1], 0);
    wait_jobs(1, 100);
    repeat (4) cyc();

`ifdef GCD_ARB_TIMEOUT_EN
    // T6 core stalls after two beats
    stall = 1;
    start_job(4'b0001);
    bus.req = '0;
    wait_jobs(1, 200);
    stall = 0;
    chk("t6_pulse", n_to, 1);
    chk("t6_beats", last_beats, 3);
    chk("t6_last", rlog[2], 0);
    start_job(4'b0010);
    bus.req = '0;
    wait_jobs(1, 100);
    chk("t6_next", last_id, 1);
`endif

    // randomized request traffic
    c = 0;
    n = jobs_done + 24;
    while (jobs_done < n && c < 4000) begin
      if ($urandom_range(0, 2) == 0)
        bus.req = 4'($urandom_range(0, 15));
      cyc();
      c++;
    end
    chk("rand_budget", jobs_done >= n, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
